delay_line_pipe: RTL and testbench

Parametrised multi-stage delay line with per-stage valid tagging, stall, flush and a runtime-selectable tap. It is the next generation of the fixed one-cycle action/reward/state delay registers. It aligns Q-learning datapath operands (RAM action word, reward, state index) whose producers have differing latencies. One instance per aligned signal; WIDTH covers 6-bit state and 16-bit action/reward words.

---
 rtl/delay_line_pipe.sv | 89 ++++++++
 tb/tb_delay_line_pipe.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_pipe.sv
// delay_line_pipe: DEPTH-stage delay line with valid tagging, stall, flush and a runtime tap.
// Optional macro DELAY_LINE_PIPE_ZERO_INVALID_EN forces dout to zero whenever dout_valid is low.
module delay_line_pipe #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      DEPTH     = 4,
    parameter int unsigned      SEL_W     = 4,
    parameter int unsigned      CNT_W     = 5,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic [SEL_W-1:0] delay_sel,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CNT_W-1:0] inflight
);

    localparam logic [SEL_W-1:0] LP_DEPTH_SEL = SEL_W'(DEPTH);
    localparam logic [SEL_W-1:0] LP_ONE_SEL   = SEL_W'(1);

    logic [WIDTH-1:0] r_stage [1:DEPTH];
    logic [DEPTH:1]   r_valid;
    logic [CNT_W-1:0] r_cnt;

    logic [SEL_W-1:0] w_tap;
    logic [WIDTH-1:0] w_raw;
    logic             w_tap_valid;

    // Stage registers, valid tags and occupancy counter: reset > flush > advance > hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k <= int'(DEPTH); k++) begin
                r_stage[k] <= RESET_VAL;
            end
            r_valid <= '0;
            r_cnt   <= '0;
        end else if (flush) begin
            // Data contents are deliberately kept; only the tags are cleared.
            r_valid <= '0;
            r_cnt   <= '0;
        end else if (en) begin
            r_stage[1] <= din;
            r_valid[1] <= din_valid;
            for (int k = 2; k <= int'(DEPTH); k++) begin
                r_stage[k] <= r_stage[k-1];
                r_valid[k] <= r_valid[k-1];
            end
            r_cnt <= r_cnt + CNT_W'(din_valid) - CNT_W'(r_valid[DEPTH]);
        end else begin
            r_valid <= r_valid;
            r_cnt   <= r_cnt;
        end
    end

    // Effective delay: 0 behaves as 1, anything beyond DEPTH clamps to the last stage.
    always_comb begin
        w_tap = LP_ONE_SEL;
        if (delay_sel == '0) begin
            w_tap = LP_ONE_SEL;
        end else if (delay_sel > LP_DEPTH_SEL) begin
            w_tap = LP_DEPTH_SEL;
        end else begin
            w_tap = delay_sel;
        end
    end

    // DEPTH:1 tap mux; the only combinational path into dout starts at delay_sel.
    always_comb begin
        w_raw       = r_stage[1];
        w_tap_valid = r_valid[1];
        for (int k = 1; k <= int'(DEPTH); k++) begin
            w_raw       = (w_tap == SEL_W'(k)) ? r_stage[k] : w_raw;
            w_tap_valid = (w_tap == SEL_W'(k)) ? r_valid[k] : w_tap_valid;
        end
    end

`ifdef DELAY_LINE_PIPE_ZERO_INVALID_EN
    assign dout = w_tap_valid ? w_raw : '0;
`else
    assign dout = w_raw;
`endif
    assign dout_valid = w_tap_valid;
    assign inflight   = r_cnt;

endmodule

// File: tb/tb_delay_line_pipe.sv
// Self-checking bench for delay_line_pipe: history-queue reference model plus directed literal checks.
// Honours DELAY_LINE_PIPE_ZERO_INVALID_EN when expecting dout on invalid cycles.
module tb_delay_line_pipe;

    localparam logic [15:0] RV = 16'h1234;
`ifdef DELAY_LINE_PIPE_ZERO_INVALID_EN
    localparam logic        ZERO_INV = 1'b1;
`else
    localparam logic        ZERO_INV = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, en, flush, din_valid;
    logic [15:0] din;
    logic [3:0]  delay_sel;
    logic [15:0] dout;
    logic        dout_valid;
    logic [4:0]  inflight;

    int checks = 0;
    int errors = 0;

    delay_line_pipe #(
        .WIDTH(16), .DEPTH(4), .SEL_W(4), .CNT_W(5), .RESET_VAL(RV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .din(din), .din_valid(din_valid), .delay_sel(delay_sel),
        .dout(dout), .dout_valid(dout_valid), .inflight(inflight)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: every accepted push since reset, oldest first; entries before
    // flush_mark were invalidated by a flush.
    logic [15:0] h_data[$];
    logic        h_valid[$];
    int          flush_mark = 0;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            h_data.delete();
            h_valid.delete();
            flush_mark <= 0;
            m_live     <= 1'b1;
        end else if (flush) begin
            flush_mark <= h_data.size();
        end else if (en) begin
            h_data.push_back(din);
            h_valid.push_back(din_valid);
        end
    end

    function automatic int eff_delay(input logic [3:0] s);
        if (s == 4'd0) return 1;
        if (s > 4'd4) return 4;
        return int'(s);
    endfunction

    int          c_n, c_d, c_idx, c_lo, c_cnt;
    logic [15:0] c_data;
    logic        c_valid;

    // Compare DUT against the model in the middle of every cycle after the first reset edge.
    always @(negedge clk) begin
        if (m_live) begin
            c_n = h_data.size();
            c_d = eff_delay(delay_sel);
            if (c_n >= c_d) begin
                c_idx   = c_n - c_d;
                c_data  = h_data[c_idx];
                c_valid = h_valid[c_idx] && (c_idx >= flush_mark);
            end else begin
                c_data  = RV;
                c_valid = 1'b0;
            end
            if (ZERO_INV && !c_valid) c_data = 16'h0000;
            c_lo = c_n - 4;
            if (c_lo < flush_mark) c_lo = flush_mark;
            if (c_lo < 0) c_lo = 0;
            c_cnt = 0;
            for (int i = c_lo; i < c_n; i++) if (h_valid[i]) c_cnt++;
            chk("model_dout", 32'(dout), 32'(c_data));
            chk("model_dout_valid", 32'(dout_valid), 32'(c_valid));
            chk("model_inflight", 32'(inflight), 32'(c_cnt));
            chk("inflight_bound", 32'(inflight <= 5'd4), 32'd1);
        end
    end

    task automatic step(input logic r, input logic f, input logic e,
                        input logic [15:0] d, input logic dv, input logic [3:0] s);
        rst_n = r; flush = f; en = e; din = d; din_valid = dv; delay_sel = s;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] inv_dout(input logic [15:0] raw);
        return ZERO_INV ? 16'h0000 : raw;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; en = 1'b0; din = 16'h0000; din_valid = 1'b0; delay_sel = 4'd3;

        // Reset for two edges
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd3);
        step(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd3);
        chk("rst_dout", 32'(dout), 32'(inv_dout(RV)));
        chk("rst_valid", 32'(dout_valid), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);

        // Latency at d=3
        step(1'b1, 1'b0, 1'b1, 16'hA5A5, 1'b1, 4'd3);
        chk("lat_infl_1", 32'(inflight), 32'd1);
        chk("lat_valid_e0", 32'(dout_valid), 32'd0);
        step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd3);
        chk("lat_valid_e1", 32'(dout_valid), 32'd0);
        step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd3);
        chk("lat_dout_e2", 32'(dout), 32'h0000A5A5);
        chk("lat_valid_e2", 32'(dout_valid), 32'd1);
        step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd3);
        chk("lat_valid_e3", 32'(dout_valid), 32'd0);
        chk("lat_infl_e3", 32'(inflight), 32'd1);
        step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd3);
        chk("lat_infl_e4", 32'(inflight), 32'd0);

        // Stall mid-stream at d=4
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b0, 1'b1, 16'(i), 1'b1, 4'd4);
        chk("stall_pre_valid", 32'(dout_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0, 16'hDEAD, 1'b1, 4'd4);
        chk("stall_infl_1", 32'(inflight), 32'd3);
        step(1'b1, 1'b0, 1'b0, 16'hDEAD, 1'b1, 4'd4);
        chk("stall_infl_2", 32'(inflight), 32'd3);
        chk("stall_hold_valid", 32'(dout_valid), 32'd0);
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd4);
            chk("stall_out_data", 32'(dout), 32'(i));
            chk("stall_out_valid", 32'(dout_valid), 32'd1);
        end
        step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd4);

        // Flush priority over en
        step(1'b1, 1'b0, 1'b1, 16'h0011, 1'b1, 4'd4);
        step(1'b1, 1'b0, 1'b1, 16'h0022, 1'b1, 4'd4);
        step(1'b1, 1'b0, 1'b1, 16'h0033, 1'b1, 4'd4);
        step(1'b1, 1'b0, 1'b1, 16'h0044, 1'b1, 4'd4);
        chk("fill_infl", 32'(inflight), 32'd4);
        chk("fill_dout", 32'(dout), 32'h00000011);
        step(1'b1, 1'b1, 1'b1, 16'h00FF, 1'b1, 4'd4);
        chk("flush_infl", 32'(inflight), 32'd0);
        chk("flush_valid", 32'(dout_valid), 32'd0);
        chk("flush_dout_kept", 32'(dout), 32'(inv_dout(16'h0011)));
        for (int s = 1; s <= 4; s++) begin
            step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 4'(s));
            chk("flush_no_00ff", 32'(dout_valid && (dout == 16'h00FF)), 32'd0);
        end

        // Tap change and clamping under en=0
        step(1'b1, 1'b0, 1'b1, 16'd10, 1'b1, 4'd1);
        step(1'b1, 1'b0, 1'b1, 16'd20, 1'b1, 4'd1);
        step(1'b1, 1'b0, 1'b1, 16'd30, 1'b1, 4'd1);
        step(1'b1, 1'b0, 1'b1, 16'd40, 1'b1, 4'd1);
        en = 1'b0; din_valid = 1'b0;
        delay_sel = 4'd1; #1; chk("tap_sel1", 32'(dout), 32'd40);
        delay_sel = 4'd2; #1; chk("tap_sel2", 32'(dout), 32'd30);
        delay_sel = 4'd0; #1; chk("tap_sel0", 32'(dout), 32'd40);
        delay_sel = 4'd9; #1; chk("tap_sel9", 32'(dout), 32'd10);
        chk("tap_sel9_valid", 32'(dout_valid), 32'd1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 4'd9);

        // Reset mid-operation with three samples in flight
        step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd2);
        step(1'b1, 1'b0, 1'b1, 16'h000A, 1'b1, 4'd2);
        step(1'b1, 1'b0, 1'b1, 16'h000B, 1'b1, 4'd2);
        step(1'b1, 1'b0, 1'b1, 16'h000C, 1'b1, 4'd2);
        chk("mid_infl", 32'(inflight), 32'd3);
        step(1'b0, 1'b0, 1'b1, 16'h000D, 1'b1, 4'd2);
        chk("mid_rst_dout", 32'(dout), 32'(inv_dout(RV)));
        chk("mid_rst_valid", 32'(dout_valid), 32'd0);
        chk("mid_rst_infl", 32'(inflight), 32'd0);
        step(1'b1, 1'b0, 1'b1, 16'h0077, 1'b1, 4'd2);
        chk("post_rst_early", 32'(dout_valid), 32'd0);
        step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 4'd2);
        chk("post_rst_dout", 32'(dout), 32'h00000077);
        chk("post_rst_valid", 32'(dout_valid), 32'd1);

        // Bubble sample: raw data visible only without the zeroing option
        step(1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0, 4'd1);
        chk("bubble_dout", 32'(dout), 32'(inv_dout(16'hBEEF)));
        chk("bubble_valid", 32'(dout_valid), 32'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 16'(i * 3), i[0], 4'(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
